pacman_mover: RTL and testbench
===============================

# pacman_mover

Movement controller that generates the `valid` / `new_x` / `new_y` stream consumed by the Pac-Man position register. The position register in turn feeds old and current coordinates to the painter.

On each game tick the block:
- reads the player direction;
- checks the target tile against the maze wall ROM;
- applies a buffered turn when legal, otherwise continues the current heading;
- issues a one-cycle move strobe.

The block sits between the joystick/direction decoder and the position register.

## Interface

Parameters:
- `START_X`, default 13: reset x tile.
- `START_Y`, default 23: reset y tile.
- `TUNNEL_Y`, default 14: row with horizontal wrap-around.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `tick`  in  1  game-step strobe, one cycle wide.
- `dir_in`  in  3  requested direction: 0 none, 1 up, 2 down, 3 left, 4 right. Values 5–7 are treated as none.
- `cur_x`, `cur_y`  in  5 each  current tile, from the position register.
- `wall_req`  out  1  wall ROM read strobe.
- `wall_x`, `wall_y`  out  5 each  ROM address; held stable while `wall_req` is high.
- `wall_rdata`  in  1  1 = wall. Valid exactly one cycle after `wall_req`.
- `valid`  out  1  move strobe, one cycle wide.
- `new_x`, `new_y`  out  5 each  target tile; meaningful when `valid` = 1 and held otherwise.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation

Registers:
- `heading`: reset value LEFT.
- `pending`: reset value none.
- `pending` loads `dir_in` on every clock edge where `dir_in` is in 1–4.
- `pending` is cleared to none when it is promoted to `heading`.

Target computation, from `cur` and a direction:
- up: y−1. down: y+1. left: x−1. right: x+1.
- Maze is 28×31: x in 0–27, y in 0–30.
- On row `TUNNEL_Y`: x=0 moving left gives 27; x=27 moving right gives 0.
- Any other target outside the maze is forced to "wall". The ROM read is still issued so that timing stays fixed.
- Direction none is forced to "wall".

FSM states:
- IDLE → PEND_REQ on `tick`. A `tick` in any other state is ignored.
- PEND_REQ: `wall_req`=1 with the address of `pending`'s target. → PEND_WAIT.
- PEND_WAIT: sample `wall_rdata`.
  - Open: set `heading` ← `pending`, clear `pending`, latch the target. → EMIT.
  - Wall: → HEAD_REQ.
- HEAD_REQ: `wall_req`=1 with the address of `heading`'s target. → HEAD_WAIT.
- HEAD_WAIT: sample `wall_rdata`.
  - Open: latch the target. → EMIT.
  - Wall: → IDLE with no strobe. Pac-Man stays put and `heading` is kept.
- EMIT: `valid`=1 for one cycle with the latched `new_x`/`new_y`. → IDLE.

Other rules:
- `cur_x`/`cur_y` are sampled in the REQ states only.
- `reset` in any state forces IDLE.

## Timing

- Reset values:
  - `valid`=0, `wall_req`=0, `busy`=0.
  - `new_x`=`START_X`, `new_y`=`START_Y`.
  - `wall_x`/`wall_y`=`START_X`/`START_Y`.
- Turn accepted: `tick` in cycle T gives `valid` in T+3.
- Turn rejected, heading accepted: `valid` in T+5.
- Both rejected: no `valid`; `busy` drops at T+5.
- `dir_in` sampled in the same cycle as `tick` is used for that step.
- `wall_req` is never high for two consecutive cycles.
- Reset mid-operation:
  - No `valid` is emitted for the aborted step.
  - An open `wall_rdata` arriving after reset is ignored.

## Structure

- `pacman_pkg` holds:
  - `dir_t` enum (NONE, UP, DOWN, LEFT, RIGHT);
  - `MAZE_W`=28, `MAZE_H`=31;
  - default start and tunnel constants;
  - `state_t`.
- One sub-module, `pacman_step`: a combinational block taking `cur`, a direction and `TUNNEL_Y`, and returning the target x/y plus an `out_of_bounds` flag. It is instantiated once and muxed by state.

## Test plan

- Reset, no `dir_in`, open tile at (12,23), `tick` → `wall_req` at T+1 and T+3; `valid` at T+5 with (12,23).
- `dir_in`=1 held, tile (13,22) open, `tick` → `valid` at T+3 with (13,22); `heading`=UP; `pending`=none.
- `dir_in`=1, (13,22) wall, (12,23) open → fallback; `valid` at T+5 with (12,23); `heading` stays LEFT.
- `cur`=(0,14), `heading` LEFT, `tick` → `wall_x`=27; `valid` with (27,14). `cur`=(0,5) LEFT → forced wall, no `valid`.
- Second `tick` at T+1 and `reset` asserted at T+2 → no `valid` ever; FSM in IDLE and outputs at reset values at T+3.
- `dir_in`=4 pulsed for one cycle well before `tick`, right tile open → turn taken on the next `tick` (buffered).

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man movement controller.
package pacman_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PEND_REQ  = 3'd1,
    PEND_WAIT = 3'd2,
    HEAD_REQ  = 3'd3,
    HEAD_WAIT = 3'd4,
    EMIT      = 3'd5
  } state_t;

  localparam int MAZE_W       = 28;
  localparam int MAZE_H       = 31;
  localparam int DEF_START_X  = 13;
  localparam int DEF_START_Y  = 23;
  localparam int DEF_TUNNEL_Y = 14;

  // Raw joystick codes 5-7 carry no direction.
  function automatic dir_t to_dir(input logic [2:0] raw);
    dir_t d;
    case (raw)
      3'd1:    d = UP;
      3'd2:    d = DOWN;
      3'd3:    d = LEFT;
      3'd4:    d = RIGHT;
      default: d = NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pacman_step.sv
// Combinational neighbour-tile calculator with tunnel wrap and maze bounds check.
module pacman_step
  import pacman_pkg::*;
#(
  parameter int TUNNEL_Y = DEF_TUNNEL_Y
) (
  input  logic [4:0] cur_x,
  input  logic [4:0] cur_y,
  input  dir_t       dir,
  output logic [4:0] tgt_x,
  output logic [4:0] tgt_y,
  output logic       out_of_bounds
);

  logic [5:0] nx;
  logic [5:0] ny;
  logic       noDir;

  // Six-bit arithmetic lets a step off the low edge wrap to a large value that fails the bound test.
  always_comb begin
    nx    = {1'b0, cur_x};
    ny    = {1'b0, cur_y};
    noDir = 1'b0;
    case (dir)
      UP:      ny = ny - 6'd1;
      DOWN:    ny = ny + 6'd1;
      LEFT:    nx = nx - 6'd1;
      RIGHT:   nx = nx + 6'd1;
      default: noDir = 1'b1;
    endcase
    if (cur_y == 5'(TUNNEL_Y)) begin
      if (dir == LEFT && cur_x == 5'd0)
        nx = 6'(MAZE_W - 1);
      if (dir == RIGHT && cur_x == 5'(MAZE_W - 1))
        nx = 6'd0;
    end
  end

  assign tgt_x         = nx[4:0];
  assign tgt_y         = ny[4:0];
  assign out_of_bounds = noDir || (nx >= 6'(MAZE_W)) || (ny >= 6'(MAZE_H));

endmodule

// File: rtl/pacman_mover.sv
// Per-tick movement FSM: tries the buffered turn, falls back to the current heading,
// and strobes the resulting tile to the position register.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int START_X  = DEF_START_X,
  parameter int START_Y  = DEF_START_Y,
  parameter int TUNNEL_Y = DEF_TUNNEL_Y
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] dir_in,
  input  logic [4:0] cur_x,
  input  logic [4:0] cur_y,
  output logic       wall_req,
  output logic [4:0] wall_x,
  output logic [4:0] wall_y,
  input  logic       wall_rdata,
  output logic       valid,
  output logic [4:0] new_x,
  output logic [4:0] new_y,
  output logic       busy
);

  state_t     state_q,   state_d;
  dir_t       heading_q, heading_d;
  dir_t       pending_q, pending_d;
  logic [4:0] newX_q,    newX_d;
  logic [4:0] newY_q,    newY_d;
  logic [4:0] addrX_q,   addrX_d;
  logic [4:0] addrY_q,   addrY_d;
  logic       oob_q,     oob_d;

  dir_t       reqDir;
  dir_t       dirIn;
  logic [4:0] stepX;
  logic [4:0] stepY;
  logic       stepOob;
  logic       tileOpen;

  assign dirIn    = to_dir(dir_in);
  assign reqDir   = (state_q == PEND_REQ) ? pending_q : heading_q;
  assign tileOpen = !wall_rdata && !oob_q;

  pacman_step #(.TUNNEL_Y(TUNNEL_Y)) u_step (
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .dir           (reqDir),
    .tgt_x         (stepX),
    .tgt_y         (stepY),
    .out_of_bounds (stepOob)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      heading_q <= LEFT;
      pending_q <= NONE;
      newX_q    <= 5'(START_X);
      newY_q    <= 5'(START_Y);
      addrX_q   <= 5'(START_X);
      addrY_q   <= 5'(START_Y);
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      pending_q <= pending_d;
      newX_q    <= newX_d;
      newY_q    <= newY_d;
      addrX_q   <= addrX_d;
      addrY_q   <= addrY_d;
      oob_q     <= oob_d;
    end
  end

  // Promotion of the pending turn takes priority over a fresh joystick load on the same edge.
  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    pending_d = pending_q;
    newX_d    = newX_q;
    newY_d    = newY_q;
    addrX_d   = addrX_q;
    addrY_d   = addrY_q;
    oob_d     = oob_q;
    wall_req  = 1'b0;
    valid     = 1'b0;

    if (dirIn != NONE)
      pending_d = dirIn;

    case (state_q)
      IDLE: begin
        if (tick)
          state_d = PEND_REQ;
      end
      PEND_REQ, HEAD_REQ: begin
        wall_req = 1'b1;
        addrX_d  = stepX;
        addrY_d  = stepY;
        oob_d    = stepOob;
        state_d  = (state_q == PEND_REQ) ? PEND_WAIT : HEAD_WAIT;
      end
      PEND_WAIT: begin
        if (tileOpen) begin
          heading_d = pending_q;
          pending_d = NONE;
          newX_d    = addrX_q;
          newY_d    = addrY_q;
          state_d   = EMIT;
        end else begin
          state_d = HEAD_REQ;
        end
      end
      HEAD_WAIT: begin
        if (tileOpen) begin
          newX_d  = addrX_q;
          newY_d  = addrY_q;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wall_x = wall_req ? stepX : addrX_q;
  assign wall_y = wall_req ? stepY : addrY_q;
  assign new_x  = newX_q;
  assign new_y  = newY_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with a behavioural one-cycle-latency wall ROM.
module tb_pacman_mover;
  import pacman_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] dir_in = 3'd0;
  logic [4:0] cur_x = 5'd13;
  logic [4:0] cur_y = 5'd23;
  logic       wall_req;
  logic [4:0] wall_x;
  logic [4:0] wall_y;
  logic       wall_rdata = 1'b1;
  logic       valid;
  logic [4:0] new_x;
  logic [4:0] new_y;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic wallMap [0:31][0:31];

  int         validAt;
  logic [4:0] vx, vy;
  logic [4:0] ax1, ay1, ax3, ay3;
  logic [7:0] reqMask;
  logic [7:0] busyMask;
  dir_t       headAtValid;
  dir_t       pendAtValid;

  pacman_mover dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .dir_in     (dir_in),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .wall_req   (wall_req),
    .wall_x     (wall_x),
    .wall_y     (wall_y),
    .wall_rdata (wall_rdata),
    .valid      (valid),
    .new_x      (new_x),
    .new_y      (new_y),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Unrequested cycles read back as wall so mistimed sampling shows up.
  always @(posedge clock)
    wall_rdata <= wall_req ? wallMap[wall_y][wall_x] : 1'b1;

  task automatic clearMap();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        wallMap[y][x] = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1; tick = 1'b0; dir_in = 3'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Pulses tick with tickDir, then holds holdDir and records seven cycles of outputs.
  task automatic runStep(input logic [2:0] tickDir, input logic [2:0] holdDir);
    tick = 1'b1; dir_in = tickDir;
    @(posedge clock); #1;
    tick = 1'b0; dir_in = holdDir;
    validAt = 0; reqMask = '0; busyMask = '0;
    vx = '0; vy = '0; ax1 = '0; ay1 = '0; ax3 = '0; ay3 = '0;
    headAtValid = NONE; pendAtValid = NONE;
    for (int k = 1; k <= 7; k++) begin
      reqMask[k]  = wall_req;
      busyMask[k] = busy;
      if (k == 1) begin ax1 = wall_x; ay1 = wall_y; end
      if (k == 3) begin ax3 = wall_x; ay3 = wall_y; end
      if (valid && validAt == 0) begin
        validAt = k; vx = new_x; vy = new_y;
        headAtValid = dut.heading_q; pendAtValid = dut.pending_q;
      end
      @(posedge clock); #1;
    end
    dir_in = 3'd0;
  endtask

  task automatic test_reset();
    clearMap();
    cur_x = 5'd13; cur_y = 5'd23;
    applyReset();
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (wall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_wall_req: got %0b expected 0", wall_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (new_x !== 5'd13 || new_y !== 5'd23) begin errors++; $display("[TB] FAIL reset_new_xy: got (%0d,%0d) expected (13,23)", new_x, new_y); end
    checks++; if (wall_x !== 5'd13 || wall_y !== 5'd23) begin errors++; $display("[TB] FAIL reset_wall_xy: got (%0d,%0d) expected (13,23)", wall_x, wall_y); end
  endtask

  task automatic test_heading_only();
    clearMap();
    cur_x = 5'd13; cur_y = 5'd23;
    applyReset();
    runStep(3'd0, 3'd0);
    checks++; if (reqMask !== 8'b0000_1010) begin errors++; $display("[TB] FAIL heading_req_mask: got %b expected 00001010", reqMask); end
    checks++; if (ax3 !== 5'd12 || ay3 !== 5'd23) begin errors++; $display("[TB] FAIL heading_addr: got (%0d,%0d) expected (12,23)", ax3, ay3); end
    checks++; if (validAt != 5) begin errors++; $display("[TB] FAIL heading_valid_cycle: got %0d expected 5", validAt); end
    checks++; if (vx !== 5'd12 || vy !== 5'd23) begin errors++; $display("[TB] FAIL heading_target: got (%0d,%0d) expected (12,23)", vx, vy); end
    // Code 5 is not a direction: same fallback as no input.
    applyReset();
    runStep(3'd5, 3'd0);
    checks++; if (validAt != 5 || vx !== 5'd12) begin errors++; $display("[TB] FAIL dir5_as_none: got cycle %0d x %0d expected cycle 5 x 12", validAt, vx); end
  endtask

  task automatic test_turn_accept();
    clearMap();
    cur_x = 5'd13; cur_y = 5'd23;
    applyReset();
    runStep(3'd1, 3'd1);
    checks++; if (ax1 !== 5'd13 || ay1 !== 5'd22) begin errors++; $display("[TB] FAIL turn_addr: got (%0d,%0d) expected (13,22)", ax1, ay1); end
    checks++; if (reqMask !== 8'b0000_0010) begin errors++; $display("[TB] FAIL turn_req_mask: got %b expected 00000010", reqMask); end
    checks++; if (validAt != 3) begin errors++; $display("[TB] FAIL turn_valid_cycle: got %0d expected 3", validAt); end
    checks++; if (vx !== 5'd13 || vy !== 5'd22) begin errors++; $display("[TB] FAIL turn_target: got (%0d,%0d) expected (13,22)", vx, vy); end
    checks++; if (headAtValid !== UP) begin errors++; $display("[TB] FAIL turn_heading: got %0d expected %0d", headAtValid, UP); end
    checks++; if (pendAtValid !== NONE) begin errors++; $display("[TB] FAIL turn_pending: got %0d expected %0d", pendAtValid, NONE); end
  endtask

  task automatic test_turn_reject();
    clearMap();
    wallMap[22][13] = 1'b1;
    cur_x = 5'd13; cur_y = 5'd23;
    applyReset();
    runStep(3'd1, 3'd0);
    checks++; if (validAt != 5) begin errors++; $display("[TB] FAIL reject_valid_cycle: got %0d expected 5", validAt); end
    checks++; if (vx !== 5'd12 || vy !== 5'd23) begin errors++; $display("[TB] FAIL reject_target: got (%0d,%0d) expected (12,23)", vx, vy); end
    checks++; if (headAtValid !== LEFT) begin errors++; $display("[TB] FAIL reject_heading: got %0d expected %0d", headAtValid, LEFT); end
    checks++; if (pendAtValid !== UP) begin errors++; $display("[TB] FAIL reject_pending: got %0d expected %0d", pendAtValid, UP); end
  endtask

  task automatic test_tunnel();
    clearMap();
    cur_x = 5'd0; cur_y = 5'd14;
    applyReset();
    runStep(3'd0, 3'd0);
    checks++; if (ax3 !== 5'd27 || ay3 !== 5'd14) begin errors++; $display("[TB] FAIL tunnel_addr: got (%0d,%0d) expected (27,14)", ax3, ay3); end
    checks++; if (validAt != 5 || vx !== 5'd27 || vy !== 5'd14) begin errors++; $display("[TB] FAIL tunnel_target: got cycle %0d (%0d,%0d) expected cycle 5 (27,14)", validAt, vx, vy); end
    // Off-maze target on a normal row is a wall even though the ROM reads open.
    cur_x = 5'd0; cur_y = 5'd5;
    runStep(3'd0, 3'd0);
    checks++; if (validAt != 0) begin errors++; $display("[TB] FAIL edge_no_valid: got cycle %0d expected none", validAt); end
    checks++; if (busyMask !== 8'b0001_1110) begin errors++; $display("[TB] FAIL edge_busy_mask: got %b expected 00011110", busyMask); end
    checks++; if (reqMask !== 8'b0000_1010) begin errors++; $display("[TB] FAIL edge_req_mask: got %b expected 00001010", reqMask); end
  endtask

  task automatic test_buffered();
    clearMap();
    cur_x = 5'd13; cur_y = 5'd23;
    applyReset();
    dir_in = 3'd4;
    @(posedge clock); #1 dir_in = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    runStep(3'd0, 3'd0);
    checks++; if (validAt != 3 || vx !== 5'd14 || vy !== 5'd23) begin errors++; $display("[TB] FAIL buffered_turn: got cycle %0d (%0d,%0d) expected cycle 3 (14,23)", validAt, vx, vy); end
    checks++; if (headAtValid !== RIGHT) begin errors++; $display("[TB] FAIL buffered_heading: got %0d expected %0d", headAtValid, RIGHT); end
    cur_x = 5'd27; cur_y = 5'd14;
    runStep(3'd0, 3'd0);
    checks++; if (ax3 !== 5'd0 || validAt != 5 || vx !== 5'd0 || vy !== 5'd14) begin errors++; $display("[TB] FAIL tunnel_right: got addr %0d cycle %0d (%0d,%0d) expected addr 0 cycle 5 (0,14)", ax3, validAt, vx, vy); end
  endtask

  task automatic test_reset_mid();
    int sawValid;
    int sawBusy;
    clearMap();
    cur_x = 5'd13; cur_y = 5'd23;
    applyReset();
    tick = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tick = 1'b0;
    checks++; if (wall_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL second_tick_ignored: got req %0b busy %0b expected req 0 busy 1", wall_req, busy); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (valid !== 1'b0 || wall_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl: got valid %0b req %0b busy %0b expected 0 0 0", valid, wall_req, busy); end
    checks++; if (new_x !== 5'd13 || new_y !== 5'd23 || wall_x !== 5'd13 || wall_y !== 5'd23) begin errors++; $display("[TB] FAIL midreset_xy: got new (%0d,%0d) wall (%0d,%0d) expected (13,23) (13,23)", new_x, new_y, wall_x, wall_y); end
    sawValid = 0; sawBusy = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid) sawValid++;
      if (busy) sawBusy++;
      @(posedge clock); #1;
    end
    checks++; if (sawValid != 0 || sawBusy != 0) begin errors++; $display("[TB] FAIL midreset_quiet: got %0d valid %0d busy cycles expected 0 0", sawValid, sawBusy); end
  endtask

  initial begin
    test_reset();
    test_heading_only();
    test_turn_accept();
    test_turn_reject();
    test_tunnel();
    test_buffered();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
